// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared constants for the execute-stage register-address path
package ex_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Register $zero: writes to it are discarded, so it doubles as the bubble value.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/mux2.sv
// rtl/mux2.sv - generic 2:1 combinational mux with X-propagating select
module mux2
    import ex_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // An unknown select must poison the result rather than quietly pick a side.
    always_comb begin
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_ex.sv
// rtl/mux_ex.sv - EX-stage destination-register select with registered EX/MEM copy
module mux_ex
    import ex_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;

    mux2 #(
        .WIDTH (WIDTH)
    ) u_mux2 (
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (w_y)
    );

    // Reset and flush both insert a bubble targeting $zero; en=0 is a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q <= WIDTH'(REG_ZERO);
        end else if (flush) begin
            r_y_q <= WIDTH'(REG_ZERO);
        end else if (en) begin
            r_y_q <= w_y;
        end
    end

    assign y   = w_y;
    assign y_q = r_y_q;

endmodule

// File: tb/tb_mux_ex.sv
// tb/tb_mux_ex.sv - scoreboard bench for mux_ex
module tb_mux_ex;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [4:0] a;
    logic [4:0] b;
    logic       sel;
    logic [4:0] y;
    logic [4:0] y_q;

    logic [4:0] sb_y[$];
    logic [4:0] sb_q[$];
    logic [4:0] exp_v;
    logic [4:0] m_q;
    int         n_checks;
    int         n_errors;

    mux_ex #(
        .WIDTH (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .flush (flush),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .y     (y),
        .y_q   (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] ref_y(input logic [4:0] fa, input logic [4:0] fb, input logic fs);
        if (fs === 1'b0) return fa;
        if (fs === 1'b1) return fb;
        return 5'bxxxxx;
    endfunction

    // Advances the register model one edge from the inputs currently applied.
    function automatic logic [4:0] next_q(input logic [4:0] cur);
        if (rst_n == 1'b0) return 5'b00000;
        if (flush) return 5'b00000;
        if (en) return ref_y(a, b, sel);
        return cur;
    endfunction

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a = 5'b00000; b = 5'b10101; sel = 1'b1; en = 1'b1; flush = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(5'b00000);
            edge_wait();
            exp_v = sb_q.pop_front();
            n_checks++;
            if (y_q !== exp_v) begin
                n_errors++;
                $display("FAIL reset_yq[%0d]: got %b want %b", i, y_q, exp_v);
            end
        end
        sb_y.push_back(5'b10101);
        exp_v = sb_y.pop_front();
        n_checks++;
        if (y !== exp_v) begin
            n_errors++;
            $display("FAIL reset_y_unreset: got %b want %b", y, exp_v);
        end
        rst_n = 1'b1;
        sb_q.push_back(5'b10101);
        edge_wait();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (y_q !== exp_v) begin
            n_errors++;
            $display("FAIL reset_release_load: got %b want %b", y_q, exp_v);
        end
        m_q = 5'b10101;
    endtask

    task automatic test_comb();
        logic [4:0] st_a[6];
        logic [4:0] st_b[6];
        logic       st_s[6];
        logic [4:0] st_y[6];
        st_a = '{5'b01010, 5'b00000, 5'b00000, 5'b00101, 5'b00101, 5'b11000};
        st_b = '{5'b10101, 5'b10101, 5'b11111, 5'b11111, 5'b11101, 5'b11101};
        st_s = '{1'b1,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0};
        st_y = '{5'b10101, 5'b10101, 5'b11111, 5'b11111, 5'b00101, 5'b11000};
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = st_a[i]; b = st_b[i]; sel = st_s[i];
            sb_y.push_back(st_y[i]);
            #1;
            exp_v = sb_y.pop_front();
            n_checks++;
            if (y !== exp_v) begin
                n_errors++;
                $display("FAIL comb_step%0d: got %b want %b", i, y, exp_v);
            end
        end
        a = 5'b00101; b = 5'b11101; sel = 1'bx;
        #1;
        if ($isunknown(sel)) begin
            n_checks++;
            if (y !== 5'bxxxxx) begin
                n_errors++;
                $display("FAIL comb_sel_x: got %b want xxxxx", y);
            end
        end
        sel = 1'b0;
        #1;
    endtask

    task automatic test_stall();
        en = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 5'($urandom); b = 5'($urandom); sel = 1'($urandom);
            sb_y.push_back(ref_y(a, b, sel));
            sb_q.push_back(m_q);
            #1;
            exp_v = sb_y.pop_front();
            n_checks++;
            if (y !== exp_v) begin
                n_errors++;
                $display("FAIL stall_y[%0d]: got %b want %b", i, y, exp_v);
            end
            edge_wait();
            exp_v = sb_q.pop_front();
            n_checks++;
            if (y_q !== exp_v) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got %b want %b", i, y_q, exp_v);
            end
        end
    endtask

    task automatic test_flush();
        a = 5'b00011; b = 5'b11111; sel = 1'b1; en = 1'b1; flush = 1'b1;
        sb_q.push_back(5'b00000);
        edge_wait();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (y_q !== exp_v) begin
            n_errors++;
            $display("FAIL flush_wins: got %b want %b", y_q, exp_v);
        end
        flush = 1'b0;
        sb_q.push_back(5'b11111);
        edge_wait();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (y_q !== exp_v) begin
            n_errors++;
            $display("FAIL flush_release: got %b want %b", y_q, exp_v);
        end
        m_q = 5'b11111;
    endtask

    task automatic test_mid_reset();
        a = 5'b10001; b = 5'b01110; sel = 1'b0; en = 1'b1; flush = 1'b0;
        sb_q.push_back(5'b10001);
        edge_wait();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (y_q !== exp_v) begin
            n_errors++;
            $display("FAIL midrst_load: got %b want %b", y_q, exp_v);
        end
        rst_n = 1'b0; en = 1'b0; flush = 1'b0;
        sb_q.push_back(5'b00000);
        edge_wait();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (y_q !== exp_v) begin
            n_errors++;
            $display("FAIL midrst_clear: got %b want %b", y_q, exp_v);
        end
        rst_n = 1'b1;
        m_q = 5'b00000;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            a = 5'($urandom); b = 5'($urandom); sel = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 9) != 0);
            m_q = next_q(m_q);
            sb_q.push_back(m_q);
            edge_wait();
            exp_v = sb_q.pop_front();
            n_checks++;
            if (y_q !== exp_v) begin
                n_errors++;
                $display("FAIL b2b_yq[%0d]: got %b want %b (en=%b flush=%b rst_n=%b)",
                         i, y_q, exp_v, en, flush, rst_n);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_q = 5'b00000;
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; a = '0; b = '0; sel = 1'b0;
        #1;
        test_reset();
        test_comb();
        test_stall();
        test_flush();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
